// File: rtl/mem_exc_pkg.sv
// Shared types and constants for the memory exception controller.
package mem_exc_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_ADES = 2'd1,
    CAUSE_ADEL = 2'd2,
    CAUSE_OOB  = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_HANDLER = 3'd2,
    ST_RETURN  = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/exc_cause_encode.sv
// Priority encoder from the checker flags to a fault strobe and cause code.
// A misaligned store outranks a misaligned load, which outranks out-of-bound.
module exc_cause_encode
  import mem_exc_pkg::*;
(
  input  logic   instr_valid_i,
  input  logic   readerror_i,
  input  logic   writeerror_i,
  input  logic   outofboundaccess_i,
  output logic   fault_o,
  output cause_e cause_o
);

  // fault only counts for a live instruction; cause follows flag priority
  always_comb begin
    fault_o = instr_valid_i & (readerror_i | writeerror_i | outofboundaccess_i);
    cause_o = CAUSE_NONE;
    if (writeerror_i)           cause_o = CAUSE_ADES;
    else if (readerror_i)       cause_o = CAUSE_ADEL;
    else if (outofboundaccess_i) cause_o = CAUSE_OOB;
  end

endmodule

// File: rtl/mem_exception_ctrl.sv
// Memory exception controller: kills a faulting access, captures the fault
// context and steers fetch to the handler, then back to epc+4 on ERET.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | normal execution, watching for a fault
// FLUSH   | redirect to handler is presented; fetched instruction squashed
// HANDLER | handler running; a fault here is a double fault, ERET returns
// RETURN  | redirect to epc+4 is presented; inputs ignored
// HALT    | double fault taken; frozen until reset
module mem_exception_ctrl
  import mem_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter int          CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic             readerror,
  input  logic             writeerror,
  input  logic             outofboundaccess,
  input  logic [31:0]      pc,
  input  logic [31:0]      aluout,
  input  logic             eret,
  output logic             mem_kill,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc,
  output logic [31:0]      badvaddr,
  output logic [1:0]       cause,
  output logic             in_handler,
  output logic             double_fault,
  output logic [CNT_W-1:0] exc_count
);

  state_e           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      badvaddr_q, badvaddr_d;
  cause_e           cause_q, cause_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             double_fault_q, double_fault_d;
  logic [CNT_W-1:0] exc_count_q, exc_count_d;

  logic   fault;
  cause_e fault_cause;

  exc_cause_encode u_encode (
    .instr_valid_i      (instr_valid),
    .readerror_i        (readerror),
    .writeerror_i       (writeerror),
    .outofboundaccess_i (outofboundaccess),
    .fault_o            (fault),
    .cause_o            (fault_cause)
  );

  // next-state and capture logic; redirect is registered so it never glitches
  always_comb begin
    state_d          = state_q;
    epc_d            = epc_q;
    badvaddr_d       = badvaddr_q;
    cause_d          = cause_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    double_fault_d   = double_fault_q;
    exc_count_d      = exc_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fault) begin
          state_d          = ST_FLUSH;
          epc_d            = pc;
          badvaddr_d       = aluout;
          cause_d          = fault_cause;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = HANDLER_ADDR;
          if (exc_count_q != '1) exc_count_d = exc_count_q + CNT_W'(1);
        end
      end
      ST_FLUSH:  state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (fault) begin
          // keep the original fault context for post-mortem
          state_d        = ST_HALT;
          double_fault_d = 1'b1;
        end else if (eret) begin
          state_d          = ST_RETURN;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = epc_q + 32'd4;
          cause_d          = CAUSE_NONE;
        end
      end
      ST_RETURN: state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // state and context registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      epc_q            <= '0;
      badvaddr_q       <= '0;
      cause_q          <= CAUSE_NONE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      double_fault_q   <= 1'b0;
      exc_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      epc_q            <= epc_d;
      badvaddr_q       <= badvaddr_d;
      cause_q          <= cause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      double_fault_q   <= double_fault_d;
      exc_count_q      <= exc_count_d;
    end
  end

  // kill is combinational so the faulting store/writeback dies this cycle
  always_comb begin
    mem_kill = fault & ((state_q == ST_IDLE) | (state_q == ST_HANDLER)) & ~double_fault_q;
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign epc            = epc_q;
  assign badvaddr       = badvaddr_q;
  assign cause          = cause_q;
  assign in_handler     = (state_q == ST_HANDLER);
  assign double_fault   = double_fault_q;
  assign exc_count      = exc_count_q;

endmodule

// File: doc/mem_exception_ctrl.md
Name: mem_exception_ctrl

Overview:
Consumes the misaligned-read, misaligned-write and out-of-bound-access flags produced by the memory-access checker in the single-cycle datapath. Kills the faulting memory access in the same cycle, captures the faulting PC, address and cause, and redirects fetch to a fixed handler address. Returns via ERET.
Sits between the memory-access checker and the PC-select mux, which takes redirect_valid/redirect_pc with top priority.

Parameters:
HANDLER_ADDR, 32'h0000_0100, PC loaded on exception entry
CNT_W, 8, width of saturating exception counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
instr_valid  input  1  current instruction is architecturally live (not a bubble)
readerror  input  1  misaligned load flag from checker
writeerror  input  1  misaligned store flag from checker
outofboundaccess  input  1  data address outside 0..127 flag from checker
pc  input  32  PC of current instruction
aluout  input  32  effective data address of current instruction
eret  input  1  decoded ERET of current instruction
mem_kill  output  1  combinational; suppress data-memory write and register writeback this cycle
redirect_valid  output  1  registered; PC mux takes redirect_pc this cycle
redirect_pc  output  32  registered redirect target
epc  output  32  latched faulting PC
badvaddr  output  32  latched faulting address
cause  output  2  latched cause code
in_handler  output  1  high while in HANDLER state
double_fault  output  1  sticky; core must halt
exc_count  output  CNT_W  saturating count of taken exceptions

Behaviour:
- Reset (rst high at a posedge): state=IDLE; epc, badvaddr, redirect_pc=0; cause=CAUSE_NONE; redirect_valid, double_fault, exc_count=0. Reset overrides every other event, including reset mid-FLUSH/RETURN.
- fault = instr_valid & (readerror | writeerror | outofboundaccess).
- Cause priority when flags coincide: writeerror → CAUSE_ADES(1); else readerror → CAUSE_ADEL(2); else outofboundaccess → CAUSE_OOB(3). CAUSE_NONE=0.
- mem_kill = fault & (state==IDLE | state==HANDLER) & ~double_fault. Purely combinational, same cycle as the flags. Zero latency.
- States: IDLE, FLUSH, HANDLER, RETURN, HALT.
- IDLE + fault: at the posedge, latch epc=pc, badvaddr=aluout and cause per priority; exc_count+=1, saturating at all-ones. Next state FLUSH. The following cycle redirect_valid=1 and redirect_pc=HANDLER_ADDR.
- IDLE + eret without fault: ignored; stay IDLE. eret with fault: the fault wins.
- FLUSH: redirect_valid high for exactly 1 cycle; next state HANDLER. Inputs are ignored (the fetched instruction is squashed).
- HANDLER: in_handler=1.
  - fault: double_fault=1, next state HALT. epc, badvaddr and cause are NOT overwritten. mem_kill asserts.
  - eret (no fault): next state RETURN with redirect_pc=epc+4 (32-bit wrap), cause cleared to CAUSE_NONE.
- RETURN: redirect_valid=1 for 1 cycle; next state IDLE. Inputs ignored.
- HALT: terminal until rst. redirect_valid=0; all latched values hold; in_handler=0.
- redirect_valid is 0 in IDLE, HANDLER and HALT.
- epc, badvaddr and cause hold between exceptions. Outputs never glitch except mem_kill.

Decomposition:
- Package mem_exc_pkg: cause codes CAUSE_NONE/ADES/ADEL/OOB (2-bit), state encoding (3-bit), default HANDLER_ADDR.
- One sub-module: exc_cause_encode, combinational priority encoder (3 flags + instr_valid → fault, cause). FSM and registers stay in the top module.

Test Plan:
- rst high 1 cycle, then idle inputs → all outputs 0, state IDLE, mem_kill=0.
- pc=0x40, aluout=0x06, writeerror=1 → mem_kill=1 same cycle; next cycle redirect_valid=1, redirect_pc=0x100, epc=0x40, badvaddr=0x06, cause=1, exc_count=1; following cycle in_handler=1.
- In HANDLER, eret=1 → next cycle redirect_valid=1, redirect_pc=0x44, cause=0; then IDLE with redirect_valid=0.
- readerror=1 and outofboundaccess=1 together, pc=0x10, aluout=0x85 → cause=2 (ADEL); instr_valid=0 with flags set → no mem_kill, no capture.
- In HANDLER, outofboundaccess=1 with aluout=0x200 → mem_kill=1, double_fault=1, badvaddr unchanged; state HALT ignores eret; rst recovers to IDLE.
- 260 back-to-back fault/ERET pairs → exc_count saturates at 255; pc=0xFFFFFFFC fault then eret → redirect_pc=0x00000000.
